// File: rtl/icache_assoc_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
package icache_assoc_pkg;

  localparam int ICACHE_ADDR_W  = 17;
  localparam int ICACHE_INDEX_W = 7;
  localparam int ICACHE_WAYS    = 2;
  localparam int ICACHE_IO_BIT  = 17;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag/data arrays with a valid vector, combinational read,
// synchronous write and a single-cycle clear of every valid bit.
module icache_way #(
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);
  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      data_q [SETS];

  // Valid bits: clear wins over a same-cycle fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {SETS{1'b0}};
    end else if (clr_i) begin
      valid_q <= {SETS{1'b0}};
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage, no reset needed since valid gates every read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with its own refill FSM, LRU replacement,
// fence.i flush, uncached IO window and hit/miss counters.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int ADDR_W  = ICACHE_ADDR_W,
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int WAYS    = ICACHE_WAYS,
  parameter int IO_BIT  = ICACHE_IO_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_hit_o,
  output logic [31:0] if_inst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_inst_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int SETS  = 1 << INDEX_W;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     miss_addr_q, miss_addr_d;
  logic [31:0]     hit_cnt_q, hit_cnt_d;
  logic [31:0]     miss_cnt_q, miss_cnt_d;
  logic            victim_q, victim_d;
  logic            discard_q, discard_d;
  logic [SETS-1:0] lru_q, lru_d;

  logic [INDEX_W-1:0] rd_idx_s, fill_idx_s;
  logic [TAG_W-1:0]   rd_tag_s, fill_tag_s;
  logic               way_valid_s [WAYS];
  logic [TAG_W-1:0]   way_tag_s [WAYS];
  logic [31:0]        way_data_s [WAYS];
  logic [WAYS-1:0]    way_we_s;
  logic [WAYS-1:0]    way_match_s;
  logic               fill_s, clr_s, lookup_hit_s, hit_way_s, victim_s;
  logic [31:0]        hit_data_s;

  assign rd_idx_s   = if_addr_i[INDEX_W+1:2];
  assign rd_tag_s   = if_addr_i[ADDR_W-1:INDEX_W+2];
  assign fill_idx_s = miss_addr_q[INDEX_W+1:2];
  assign fill_tag_s = miss_addr_q[ADDR_W-1:INDEX_W+2];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign way_we_s[g] = fill_s && (victim_q == 1'(g));
    icache_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (clr_s),
      .rd_idx_i   (rd_idx_s),
      .rd_valid_o (way_valid_s[g]),
      .rd_tag_o   (way_tag_s[g]),
      .rd_data_o  (way_data_s[g]),
      .we_i       (way_we_s[g]),
      .wr_idx_i   (fill_idx_s),
      .wr_tag_i   (fill_tag_s),
      .wr_data_i  (mem_inst_i)
    );
  end

  // Tag compare across ways; victim prefers the lowest invalid way, else the LRU pick.
  always_comb begin
    way_match_s = {WAYS{1'b0}};
    victim_s    = (WAYS == 2) ? lru_q[rd_idx_s] : 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      way_match_s[w] = way_valid_s[w] && (way_tag_s[w] == rd_tag_s);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim_s = !way_valid_s[w] ? 1'(w) : victim_s;
    end
    hit_way_s    = (WAYS == 2) ? way_match_s[WAYS-1] : 1'b0;
    lookup_hit_s = (|way_match_s) && !if_addr_i[IO_BIT];
    hit_data_s   = way_data_s[hit_way_s];
  end

  // Refill FSM next state, array controls, bypass mux and counters.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    victim_d    = victim_q;
    discard_d   = discard_q;
    lru_d       = lru_q;
    fill_s      = 1'b0;
    clr_s       = 1'b0;
    if_hit_o    = 1'b0;
    if_inst_o   = 32'd0;
    if (!ready) begin
      state_d = state_q;
    end else begin
      clr_s = flush_i;
      case (state_q)
        S_IDLE: begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else if (if_req_i && lookup_hit_s) begin
            if_hit_o  = 1'b1;
            if_inst_o = hit_data_s;
            hit_cnt_d = hit_cnt_q + 32'd1;
            if (WAYS == 2) begin
              lru_d[rd_idx_s] = ~hit_way_s;
            end else begin
              lru_d = lru_q;
            end
          end else if (if_req_i) begin
            state_d     = S_FETCH;
            mem_req_d   = 1'b1;
            mem_addr_d  = word_addr(if_addr_i);
            miss_addr_d = if_addr_i;
            victim_d    = victim_s;
            discard_d   = 1'b0;
            miss_cnt_d  = miss_cnt_q + 32'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          discard_d = discard_q | flush_i;
          if (mem_valid_i) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
            // A flush seen at any point of the refill leaves the line unfilled.
            if (!miss_addr_q[IO_BIT] && !discard_q && !flush_i) begin
              fill_s = 1'b1;
              if (WAYS == 2) begin
                lru_d[fill_idx_s] = ~victim_q;
              end else begin
                lru_d = lru_q;
              end
            end else begin
              fill_s = 1'b0;
            end
            if (if_req_i && !flush_i && (if_addr_i == miss_addr_q)) begin
              if_hit_o  = 1'b1;
              if_inst_o = mem_inst_i;
            end else begin
              if_hit_o = 1'b0;
            end
          end else begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // State registers; a low ready freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      miss_addr_q <= 32'd0;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
      victim_q    <= 1'b0;
      discard_q   <= 1'b0;
      lru_q       <= {SETS{1'b0}};
    end else if (ready) begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      victim_q    <= victim_d;
      discard_q   <= discard_d;
      lru_q       <= lru_d;
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
